// File: rtl/ram_pkg.sv
// Shared types, read-during-write mode constants and the byte-lane merge helper
// for the simple-dual-port RAM.
package ram_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int MERGE_MAX_WIDTH = 1024;
   localparam int MERGE_MAX_LANES = MERGE_MAX_WIDTH / 8;

   function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
      input logic [MERGE_MAX_WIDTH-1:0] old_word,
      input logic [MERGE_MAX_WIDTH-1:0] new_word,
      input logic [MERGE_MAX_LANES-1:0] be
   );
      logic [MERGE_MAX_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MERGE_MAX_LANES; i++)
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/ram_sdp_be_init_if.sv
// Write/read port bundle of the simple-dual-port RAM; master drives requests,
// slave (the RAM) returns read data and the init status.
interface ram_sdp_be_init_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                    clear;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   logic                    rd_en;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_valid;
   logic                    init_busy;

   modport master (
      output clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy
   );

   modport slave (
      input  clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, init_busy
   );
endinterface

// File: rtl/ram_rd_pipe.sv
// Delay line for read data plus valid; data registers only load on valid so the
// output holds its last value between reads.
module ram_rd_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) data_q[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/ram_sdp_be_init.sv
// Simple-dual-port RAM with byte-lane writes, selectable read-during-write result,
// 1- or 2-cycle read latency and a zero-fill sequencer run after reset or clear.
module ram_sdp_be_init
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = RDW_OLD
) (
   input logic              clk,
   input logic              reset,
   ram_sdp_be_init_if.slave bus
);
   localparam int BYTE_LANES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LAST_FILL = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

   state_t                state;
   logic [ADDR_WIDTH:0]   fill_cnt;
   logic                  init_busy_q;
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  wr_ok;
   logic                  rd_ok;
   logic                  rd_in_range;
   logic                  rdw_hit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] s0_data;
   logic                  s0_valid;

   // clear outranks a same-cycle write; nothing from the ports is accepted outside RUN
   assign wr_ok       = (state == RUN) && bus.wr_en && !bus.clear && (32'(bus.wr_addr) < RAM_DEPTH);
   assign rd_ok       = (state == RUN) && bus.rd_en;
   assign rd_in_range = 32'(bus.rd_addr) < RAM_DEPTH;
   assign rdw_hit     = (RDW_MODE == RDW_NEW) && wr_ok && (bus.wr_addr == bus.rd_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= INIT;
         fill_cnt    <= '0;
         init_busy_q <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               if (bus.clear) begin
                  fill_cnt <= '0;
               end else if (fill_cnt == LAST_FILL) begin
                  state       <= RUN;
                  fill_cnt    <= '0;
                  init_busy_q <= 1'b0;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            RUN: begin
               if (bus.clear) begin
                  state       <= INIT;
                  fill_cnt    <= '0;
                  init_busy_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: the array has no reset branch; clearing it is the INIT sequencer's job,
   // which keeps the storage free of a reset network and lets it map to RAM macros.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[fill_cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < BYTE_LANES; i++)
            if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
   end

   // NOTE: rd_word gets a default before any branch so this block can never infer a latch.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[bus.rd_addr];
         if (rdw_hit)
            rd_word = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(mem[bus.rd_addr]),
                                             MERGE_MAX_WIDTH'(bus.wr_data),
                                             MERGE_MAX_LANES'(bus.wr_be)));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_data  <= '0;
         s0_valid <= 1'b0;
      end else begin
         s0_valid <= rd_ok;
         if (rd_ok) s0_data <= rd_word;
      end
   end

   generate
      if (READ_LATENCY > 1) begin : g_pipe
         ram_rd_pipe #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (READ_LATENCY - 1)
         ) u_rd_pipe (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (s0_valid),
            .in_data   (s0_data),
            .out_valid (bus.rd_valid),
            .out_data  (bus.rd_data)
         );
      end else begin : g_direct
         assign bus.rd_valid = s0_valid;
         assign bus.rd_data  = s0_data;
      end
   endgenerate

   assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Scoreboard bench: two RAM instances (latency 1 / old-data, latency 2 / new-data)
// driven with identical directed vectors; monitors pop expected words on rd_valid.
module tb_ram_sdp_be_init;
   import ram_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_sdp_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
   ram_sdp_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

   ram_sdp_be_init #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(RDW_OLD)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   ram_sdp_be_init #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(2), .RDW_MODE(RDW_NEW)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (ifa.rd_valid === 1'b1) begin
         if (qa.size() == 0) begin
            check("a_unexpected_rd_valid", 32'(ifa.rd_valid), 32'd0);
         end else begin
            e = qa.pop_front();
            check("a_rd_data", 32'(ifa.rd_data), 32'(e.data));
            check("a_rd_cycle", cyc, e.due);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (ifb.rd_valid === 1'b1) begin
         if (qb.size() == 0) begin
            check("b_unexpected_rd_valid", 32'(ifb.rd_valid), 32'd0);
         end else begin
            e = qb.pop_front();
            check("b_rd_data", 32'(ifb.rd_data), 32'(e.data));
            check("b_rd_cycle", cyc, e.due);
         end
      end
   end

   task automatic set_ports(input logic clr, input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [1:0] be,
                            input logic re, input logic [AW-1:0] ra);
      ifa.clear = clr; ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd; ifa.wr_be = be;
      ifa.rd_en = re;  ifa.rd_addr = ra;
      ifb.clear = clr; ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.wr_be = be;
      ifb.rd_en = re;  ifb.rd_addr = ra;
   endtask

   task automatic idle(input int n);
      set_ports(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One request cycle, entered and left at 1 time unit after a rising edge.
   task automatic op(input logic clr, input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [1:0] be,
                     input logic re, input logic [AW-1:0] ra,
                     input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
      set_ports(clr, we, wa, wd, be, re, ra);
      if (re) begin
         qa.push_back('{exp_a, cyc + 1});
         qb.push_back('{exp_b, cyc + 2});
      end
      @(posedge clk);
      #1;
      set_ports(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      op(1'b0, 1'b1, a, d, be, 1'b0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
      op(1'b0, 1'b0, '0, '0, '0, 1'b1, a, exp_a, exp_b);
   endtask

   // Counts init_busy cycles (bounded) and pokes a write+read into the fill window.
   task automatic wait_init(input string name, input logic [AW-1:0] poke_addr);
      int ca = 0;
      int cb = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (ifa.init_busy !== 1'b1 && ifb.init_busy !== 1'b1) break;
         if (ifa.init_busy === 1'b1) ca++;
         if (ifb.init_busy === 1'b1) cb++;
         if (i == 10) set_ports(1'b0, 1'b1, poke_addr, 16'hBEEF, 2'b11, 1'b1, poke_addr);
         if (i == 11) set_ports(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      end
      check({name, "_a_busy_cycles"}, ca, DEPTH);
      check({name, "_b_busy_cycles"}, cb, DEPTH);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_a_rd_data"},   32'(ifa.rd_data),   32'd0);
      check({name, "_a_rd_valid"},  32'(ifa.rd_valid),  32'd0);
      check({name, "_a_init_busy"}, 32'(ifa.init_busy), 32'd1);
      check({name, "_b_rd_data"},   32'(ifb.rd_data),   32'd0);
      check({name, "_b_rd_valid"},  32'(ifb.rd_valid),  32'd0);
      check({name, "_b_init_busy"}, 32'(ifb.init_busy), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      set_ports(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("por");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Power-up fill; the BEEF write to addr 5 inside the window must be dropped.
      wait_init("por", 8'd5);
      check("a_init_busy_run", 32'(ifa.init_busy), 32'd0);
      check("b_init_busy_run", 32'(ifb.init_busy), 32'd0);
      rd(8'd5, 16'h0000, 16'h0000);

      // Byte-lane merge across two writes.
      wr(8'h10, 16'h1234, 2'b11);
      wr(8'h10, 16'hAB00, 2'b10);
      rd(8'h10, 16'hAB34, 16'hAB34);

      // Same-address read-during-write: old data on a, merged data on b.
      wr(8'd3, 16'h1111, 2'b11);
      op(1'b0, 1'b1, 8'd3, 16'h5555, 2'b01, 1'b1, 8'd3, 16'h1111, 16'h1155);
      rd(8'd3, 16'h1155, 16'h1155);

      // wr_be=0 is a no-op; then back-to-back reads stream out in order.
      wr(8'd1, 16'hA001, 2'b11);
      wr(8'd2, 16'hA002, 2'b11);
      wr(8'd1, 16'hFFFF, 2'b00);
      rd(8'd1, 16'hA001, 16'hA001);
      rd(8'd2, 16'hA002, 16'hA002);
      rd(8'd3, 16'h1155, 16'h1155);

      // Top address.
      wr(8'hFF, 16'hFFEE, 2'b11);
      rd(8'hFF, 16'hFFEE, 16'hFFEE);
      idle(4);

      // clear with a same-cycle write to addr 7: refill, then everything reads 0.
      op(1'b1, 1'b1, 8'd7, 16'h7777, 2'b11, 1'b0, '0, '0, '0);
      wait_init("clear", 8'd7);
      for (int a = 0; a < DEPTH; a++) rd(8'(a), 16'h0000, 16'h0000);
      idle(4);

      // Reset while a read is in flight: it must vanish and rd_data must return to 0.
      wr(8'd9, 16'h9999, 2'b11);
      rd(8'd9, 16'h9999, 16'h9999);
      idle(4);
      set_ports(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd9);
      @(posedge clk);
      #1;
      set_ports(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("mid_read_reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_init("reset_restart", 8'd9);
      rd(8'd9, 16'h0000, 16'h0000);
      idle(4);

      check("a_scoreboard_drained", qa.size(), 32'd0);
      check("b_scoreboard_drained", qb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_sdp_be_init.md
Name: ram_sdp_be_init

Overview:
- Parametrised simple-dual-port RAM; next generation of the team's single-port RAM.
- Replaces the bidirectional data bus and cs/oe with a separate write port and read port, so one write and one read can complete in the same clock.
- Adds per-byte write enables, a configurable read pipeline, a selectable read-during-write mode, and a hardware zero-fill sequencer that runs after reset or on request.
- Sits between controllers and packet/frame buffers wherever a cleared, concurrently read/written store is needed.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  request re-zero of the whole array.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte-lane enables; bit i controls bits [8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- init_busy  out  1  high while the zero-fill sequencer runs; ports are ignored while high.

Behaviour:
- Reset (asynchronous assert):
  - Outputs: rd_data=0, rd_valid=0, init_busy=1.
  - Read pipeline flushed; any in-flight read is discarded and produces no rd_valid.
  - FSM goes to INIT with fill counter=0.
  - Array contents are not required to reset immediately; the INIT sequence clears them.
- FSM states:
  - INIT: each cycle writes 0 to address fill_cnt, then increments fill_cnt. After writing address RAM_DEPTH-1, go to RUN.
  - RUN: normal operation. When clear=1, go to INIT with fill_cnt=0.
- init_busy timing:
  - init_busy=1 for exactly RAM_DEPTH cycles after reset release.
  - init_busy=0 on the first RUN cycle; the sequencer is registered.
- Port behaviour during INIT: wr_en and rd_en are ignored, rd_valid stays 0, and reads already in flight are allowed to drain.
- clear in INIT: fill_cnt restarts at 0.
- clear together with wr_en in RUN: clear wins, the write is dropped, and INIT begins next cycle.
- Write: when wr_en=1 and the FSM is in RUN, only the lanes with wr_be set are updated at the clock edge. wr_be=0 is a no-op.
- Read timing (request sampled at edge N):
  - READ_LATENCY=1: rd_data and rd_valid update at edge N+1.
  - READ_LATENCY=2: rd_data and rd_valid update at edge N+2.
  - Back-to-back reads are fully pipelined, one per cycle.
- rd_data holds its last value between reads. rd_valid is high for one cycle per accepted read.
- Read-during-write (same address, same cycle):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the stored word with the enabled lanes replaced by wr_data. The merge is done in the read stage, not as a second array access.
- Out of range (address >= RAM_DEPTH, only possible when RAM_DEPTH < 2**ADDR_WIDTH):
  - Writes are ignored.
  - Reads return 0 with rd_valid=1.
- Width rules:
  - fill_cnt width is ADDR_WIDTH+1, so a full-depth count ends without wrap.
  - Byte-lane count is a localparam, DATA_WIDTH/8.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state enum {INIT, RUN}.
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - A byte-lane merge function (old word, new word, enables) -> merged word.
- One sub-module, ram_rd_pipe: a parametrised delay line for data plus valid, depth READ_LATENCY-1, flushed by reset.
- The array and FSM stay in the top module.

Test Plan (defaults unless noted):
- Reset, then release and count init_busy -> init_busy high exactly 256 cycles; during that window a write of 0xBEEF to addr 5 is dropped and a read of addr 5 once init_busy falls returns 0x0000.
- Write 0x1234 to addr 0x10 with wr_be=2'b11, then write 0xAB00 to the same addr with wr_be=2'b10, then read -> rd_data=0xAB34, rd_valid pulses one cycle after rd_en.
- Same-cycle write 0x5555 to addr 3 (old contents 0x1111) and read addr 3 -> RDW_MODE=0 returns 0x1111; RDW_MODE=1, wr_be=2'b01 returns 0x1155.
- READ_LATENCY=2, reads of addrs 1, 2, 3 on consecutive cycles -> three consecutive rd_valid pulses starting two cycles after the first rd_en, data in order.
- In RUN, pulse clear together with a write to addr 7 -> the write is dropped, init_busy is high for 256 cycles, and every address then reads 0.
- Assert reset while a READ_LATENCY=2 read is in flight -> rd_valid never pulses for it, rd_data=0, and the INIT sequence restarts.
